// File: rtl/neuraedge_noc_pkg.sv
// Shared NoC definitions for the tile command path: flit field layout,
// command opcodes, host response status codes and a flit packing helper.
package neuraedge_noc_pkg;

    localparam int unsigned FLIT_W        = 64;
    localparam int unsigned OP_W          = 4;
    localparam int unsigned TAG_W         = 4;
    localparam int unsigned ARG_W         = 16;
    localparam int unsigned DATA_W        = 32;

    // Bit offsets of each field inside a flit.
    localparam int unsigned FLIT_OP_LSB   = 60;
    localparam int unsigned FLIT_TAG_LSB  = 56;
    localparam int unsigned FLIT_ARG_LSB  = 32;
    localparam int unsigned FLIT_DATA_LSB = 0;

    // Command opcodes understood by the tile controller.
    localparam logic [OP_W-1:0] OP_NOP     = 4'h0;
    localparam logic [OP_W-1:0] OP_WRITE   = 4'h1;
    localparam logic [OP_W-1:0] OP_READ    = 4'h2;
    localparam logic [OP_W-1:0] OP_ROW_CFG = 4'h3;

    typedef enum logic [1:0] {
        RSP_OK      = 2'b00,
        RSP_TIMEOUT = 2'b01,
        RSP_POSTED  = 2'b10
    } rsp_status_t;

    // Reserved byte [55:48] is always transmitted as zero.
    function automatic logic [FLIT_W-1:0] pack_flit(
        input logic [OP_W-1:0]   op,
        input logic [TAG_W-1:0]  tag,
        input logic [ARG_W-1:0]  arg,
        input logic [DATA_W-1:0] data
    );
        return {op, tag, 8'h00, arg, data};
    endfunction

endpackage

// File: rtl/neuraedge_tile_cmd_initiator.sv
// Host-side command initiator for a NeuraEdge tile: turns one host command
// into a request flit on local port 0, optionally waits for the tagged
// response (with timeout), and returns a single response to the host.
module neuraedge_tile_cmd_initiator
    import neuraedge_noc_pkg::*;
#(
    parameter int unsigned NOC_FLIT_W     = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            cmd_opcode,
    input  logic [15:0]           cmd_arg,
    input  logic [31:0]           cmd_data,
    input  logic                  cmd_expect_resp,
    output logic [NOC_FLIT_W-1:0] tx_flit,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [NOC_FLIT_W-1:0] rx_flit,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic [1:0]            rsp_status,
    output logic                  busy,
    output logic [7:0]            drop_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t             state;
    logic [TAG_W-1:0]   tag_ctr;
    logic [TAG_W-1:0]   sent_tag;
    logic               expect_q;
    logic [15:0]        timer;

    logic [TAG_W-1:0]   rx_tag;
    logic               rx_match;
    logic               rx_drop;
    logic               timer_done;
    logic               unused_rx_bits;

    assign rx_tag     = rx_flit[FLIT_TAG_LSB +: TAG_W];
    assign rx_match   = (state == WAIT) && rx_valid && (rx_tag == sent_tag);
    assign rx_drop    = rx_valid && !rx_match;
    assign timer_done = (timer == TIMER_LAST);

    assign cmd_ready  = (state == IDLE);
    assign rx_ready   = 1'b1;
    assign busy       = (state != IDLE);

    assign unused_rx_bits = ^{rx_flit[63:60], rx_flit[55:32]};

    // Command FSM with registered tx/rsp outputs, tag counter, wait timer and drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tag_ctr    <= '0;
            sent_tag   <= '0;
            expect_q   <= 1'b0;
            timer      <= '0;
            drop_count <= '0;
            tx_valid   <= 1'b0;
            tx_flit    <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_status <= RSP_OK;
        end else begin
            if (rx_drop && (drop_count != 8'hFF))
                drop_count <= drop_count + 8'd1;

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        tx_flit  <= pack_flit(cmd_opcode, tag_ctr, cmd_arg, cmd_data);
                        tx_valid <= 1'b1;
                        sent_tag <= tag_ctr;
                        expect_q <= cmd_expect_resp;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        tag_ctr  <= tag_ctr + 4'd1;
                        timer    <= '0;
                        if (expect_q) begin
                            state <= WAIT;
                        end else begin
                            state      <= RESP;
                            rsp_valid  <= 1'b1;
                            rsp_status <= RSP_POSTED;
                            rsp_data   <= '0;
                        end
                    end
                end
                WAIT: begin
                    // A match is checked first so it wins over a same-cycle timeout.
                    if (rx_match) begin
                        state      <= RESP;
                        rsp_valid  <= 1'b1;
                        rsp_status <= RSP_OK;
                        rsp_data   <= rx_flit[FLIT_DATA_LSB +: DATA_W];
                    end else if (timer_done) begin
                        state      <= RESP;
                        rsp_valid  <= 1'b1;
                        rsp_status <= RSP_TIMEOUT;
                        rsp_data   <= '0;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuraedge_tile_cmd_initiator.sv
// Directed bench for neuraedge_tile_cmd_initiator with TIMEOUT_CYCLES=8.
module tb_neuraedge_tile_cmd_initiator;
    import neuraedge_noc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode;
    logic [15:0] cmd_arg;
    logic [31:0] cmd_data;
    logic        cmd_expect_resp;
    logic [63:0] tx_flit;
    logic        tx_valid;
    logic        tx_ready;
    logic [63:0] rx_flit;
    logic        rx_valid;
    logic        rx_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_status;
    logic        busy;
    logic [7:0]  drop_count;

    int compared   = 0;
    int mismatched = 0;

    neuraedge_tile_cmd_initiator #(
        .NOC_FLIT_W     (64),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_opcode      (cmd_opcode),
        .cmd_arg         (cmd_arg),
        .cmd_data        (cmd_data),
        .cmd_expect_resp (cmd_expect_resp),
        .tx_flit         (tx_flit),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .rx_flit         (rx_flit),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .rsp_status      (rsp_status),
        .busy            (busy),
        .drop_count      (drop_count)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle 1 ns past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"},  64'(cmd_ready),  64'd1);
        chk({tag, "_rx_ready"},   64'(rx_ready),   64'd1);
        chk({tag, "_tx_valid"},   64'(tx_valid),   64'd0);
        chk({tag, "_tx_flit"},    tx_flit,         64'd0);
        chk({tag, "_rsp_valid"},  64'(rsp_valid),  64'd0);
        chk({tag, "_rsp_data"},   64'(rsp_data),   64'd0);
        chk({tag, "_rsp_status"}, 64'(rsp_status), 64'd0);
        chk({tag, "_busy"},       64'(busy),       64'd0);
        chk({tag, "_drop_count"}, 64'(drop_count), 64'd0);
    endtask

    // Present a command for one cycle; returns with the DUT in SEND.
    task automatic issue(input logic [3:0] op, input logic [15:0] arg,
                         input logic [31:0] data, input logic expect_rsp);
        cmd_valid       = 1'b1;
        cmd_opcode      = op;
        cmd_arg         = arg;
        cmd_data        = data;
        cmd_expect_resp = expect_rsp;
        step();
        cmd_valid       = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_opcode = '0; cmd_arg = '0; cmd_data = '0;
        cmd_expect_resp = 1'b0; tx_ready = 1'b0; rx_flit = '0; rx_valid = 1'b0;
        rsp_ready = 1'b0;
        #2;
        chk_reset_outputs("por");
        step(); step();
        rst = 1'b0;
        step();

        // Read with response; tx back-pressured for 3 cycles.
        issue(OP_READ, 16'h00FF, 32'h12345678, 1'b1);
        chk("t1_cmd_ready_busy", 64'(cmd_ready), 64'd0);
        chk("t1_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 3; i++) begin
            chk("t1_tx_valid_hold", 64'(tx_valid), 64'd1);
            chk("t1_tx_flit_hold", tx_flit, 64'h200000FF12345678);
            step();
        end
        tx_ready = 1'b1;
        chk("t1_tx_flit_hs", tx_flit, 64'h200000FF12345678);
        step();
        tx_ready = 1'b0;
        chk("t1_tx_valid_drop", 64'(tx_valid), 64'd0);
        rx_flit  = 64'h00000000CAFEF00D;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t1_rsp_status", 64'(rsp_status), 64'(RSP_OK));
        chk("t1_rsp_data", 64'(rsp_data), 64'hCAFEF00D);
        step();
        chk("t1_rsp_data_hold", 64'(rsp_data), 64'hCAFEF00D);
        chk("t1_rsp_valid_hold", 64'(rsp_valid), 64'd1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("t1_rsp_done", 64'(rsp_valid), 64'd0);
        chk("t1_cmd_ready_back", 64'(cmd_ready), 64'd1);
        chk("t1_drop_count", 64'(drop_count), 64'd0);

        // Posted write: response two cycles after accept, tag now 1.
        tx_ready = 1'b1;
        issue(OP_WRITE, 16'h0010, 32'hDEADBEEF, 1'b0);
        chk("t2_tx_flit_tag1", tx_flit, 64'h11000010DEADBEEF);
        chk("t2_rsp_early", 64'(rsp_valid), 64'd0);
        step();
        tx_ready = 1'b0;
        chk("t2_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t2_rsp_status", 64'(rsp_status), 64'(RSP_POSTED));
        chk("t2_rsp_data", 64'(rsp_data), 64'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Timeout: 8 WAIT cycles with no rx (tag 2).
        tx_ready = 1'b1;
        issue(OP_READ, 16'h0001, 32'h0, 1'b1);
        chk("t3_tx_flit_tag2", tx_flit, 64'h2200000100000000);
        step();
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t3_wait_no_rsp", 64'(rsp_valid), 64'd0);
            step();
        end
        chk("t3_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t3_rsp_status", 64'(rsp_status), 64'(RSP_TIMEOUT));
        chk("t3_rsp_data", 64'(rsp_data), 64'd0);
        chk("t3_drop_count", 64'(drop_count), 64'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Wrong tag (5) dropped, then matching tag 3 accepted.
        tx_ready = 1'b1;
        issue(OP_READ, 16'h0002, 32'h0, 1'b1);
        step();
        tx_ready = 1'b0;
        rx_flit  = 64'h0500000055555555;
        rx_valid = 1'b1;
        step();
        chk("t4_drop_one", 64'(drop_count), 64'd1);
        chk("t4_no_rsp", 64'(rsp_valid), 64'd0);
        rx_flit = 64'h0300000033334444;
        step();
        rx_valid = 1'b0;
        chk("t4_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t4_rsp_status", 64'(rsp_status), 64'(RSP_OK));
        chk("t4_rsp_data", 64'(rsp_data), 64'h33334444);
        chk("t4_drop_keep", 64'(drop_count), 64'd1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Match arrives on the timeout cycle (tag 4): OK must win.
        tx_ready = 1'b1;
        issue(OP_READ, 16'h0003, 32'h0, 1'b1);
        step();
        tx_ready = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("t5_no_rsp_yet", 64'(rsp_valid), 64'd0);
        rx_flit  = 64'h04000000A5A5A5A5;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        chk("t5_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t5_rsp_status", 64'(rsp_status), 64'(RSP_OK));
        chk("t5_rsp_data", 64'(rsp_data), 64'hA5A5A5A5);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // 300 stray flits in IDLE: counter saturates at 255.
        rx_flit  = 64'h0F000000FFFFFFFF;
        rx_valid = 1'b1;
        for (int i = 0; i < 100; i++) step();
        chk("t6_drop_101", 64'(drop_count), 64'd101);
        for (int i = 0; i < 200; i++) step();
        rx_valid = 1'b0;
        chk("t6_drop_sat", 64'(drop_count), 64'd255);
        chk("t6_idle", 64'(busy), 64'd0);

        // Reset during WAIT (tag 5 in flight), then a clean transaction on tag 0.
        tx_ready = 1'b1;
        issue(OP_READ, 16'h0004, 32'h0, 1'b1);
        step();
        tx_ready = 1'b0;
        step(); step();
        chk("t7_busy_wait", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("t7_rst");
        step();
        rst = 1'b0;
        step();
        chk("t7_no_rsp_after_rst", 64'(rsp_valid), 64'd0);
        issue(OP_ROW_CFG, 16'h0ABC, 32'h01020304, 1'b1);
        chk("t7_tx_flit_tag0", tx_flit, 64'h30000ABC01020304);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        rx_flit  = 64'h000000000BADCAFE;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        chk("t7_rsp_status", 64'(rsp_status), 64'(RSP_OK));
        chk("t7_rsp_data", 64'(rsp_data), 64'h0BADCAFE);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("t7_idle_end", 64'(cmd_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
